// File: rtl/dct_ctrl_pkg.sv
// Shared types and constants for the 8x8 transform sequencing controller.
// Optional watchdog/ERROR state is enabled by defining DCT_CTRL_TIMEOUT_EN.
package dct_ctrl_pkg;

  localparam int BLK_DIM  = 8;
  localparam int IDX_W    = 3;
  localparam logic [IDX_W-1:0] LAST_IDX = 3'd7;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESTART   = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_DONE = 3'd3
`ifdef DCT_CTRL_TIMEOUT_EN
    ,
    ST_ERROR     = 3'd4
`endif
  } ctrl_state_t;

endpackage

// File: rtl/dct_ctrl_watchdog.sv
// Stall watchdog: counts consecutive stalled cycles and flags when the
// count reaches TIMEOUT_CYCLES. Any non-stalled cycle clears the count.
module dct_ctrl_watchdog
  import dct_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stall,
  output logic o_timeout
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] r_cnt;

  // Timeout fires on the stalled cycle that would make the count reach the limit.
  assign o_timeout = i_stall && (r_cnt == W'(TIMEOUT_CYCLES - 1));

  // Consecutive-stall counter; a handshake or state change is a non-stall cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_cnt <= '0;
    else if (!i_stall) r_cnt <= '0;
    else if (!o_timeout) r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/dct_block_ctrl.sv
// Sequencing controller for the 8x8 transform stage: restarts and steps the
// external double_counter, issues one coefficient request per (u,v) and
// reports block completion. Define DCT_CTRL_TIMEOUT_EN for the watchdog.
module dct_block_ctrl
  import dct_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             start_ready,
  output logic             dc_restart,
  output logic             dc_go,
  input  logic [IDX_W-1:0] dc_u,
  input  logic [IDX_W-1:0] dc_v,
  input  logic             dc_done,
  output logic             coef_valid,
  output logic [IDX_W-1:0] coef_u,
  output logic [IDX_W-1:0] coef_v,
  input  logic             coef_ready,
  output logic             blk_done,
  output logic             busy,
  output logic [CNT_W-1:0] blk_count,
  output logic             err
);

  ctrl_state_t      r_state, w_next;
  logic             r_blk_done;
  logic [CNT_W-1:0] r_blk_count;
  logic             w_hs, w_last, w_fin, w_timeout;

  assign w_hs   = coef_valid && coef_ready;
  assign w_last = w_hs && (dc_u == LAST_IDX) && (dc_v == LAST_IDX);
  assign w_fin  = (r_state == ST_WAIT_DONE) && dc_done;

`ifdef DCT_CTRL_TIMEOUT_EN
  logic w_stall;
  logic r_err;

  assign w_stall = ((r_state == ST_ISSUE) && !coef_ready) ||
                   ((r_state == ST_WAIT_DONE) && !dc_done);

  dct_ctrl_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_stall   (w_stall),
    .o_timeout (w_timeout)
  );

  // Sticky fault flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_err <= 1'b0;
    else if (w_timeout) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; start outside IDLE is dropped, not queued.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start) w_next = ST_RESTART;
      ST_RESTART:   w_next = ST_ISSUE;
      ST_ISSUE:     if (w_last) w_next = ST_WAIT_DONE;
      ST_WAIT_DONE: if (dc_done) w_next = ST_IDLE;
`ifdef DCT_CTRL_TIMEOUT_EN
      ST_ERROR:     w_next = ST_ERROR;
`endif
      default:      w_next = ST_IDLE;
    endcase
    if (w_timeout) begin
`ifdef DCT_CTRL_TIMEOUT_EN
      w_next = ST_ERROR;
`endif
    end
  end

  // State-decoded outputs; the counter only steps on an accepted request.
  always_comb begin
    start_ready = (r_state == ST_IDLE);
    dc_restart  = (r_state == ST_RESTART);
    coef_valid  = (r_state == ST_ISSUE);
    busy        = (r_state != ST_IDLE);
    dc_go       = coef_valid && coef_ready;
    coef_u      = dc_u;
    coef_v      = dc_v;
  end

  // Completion pulse and wrapping block counter, both one cycle after dc_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_done  <= 1'b0;
      r_blk_count <= '0;
    end else begin
      r_blk_done <= w_fin;
      if (w_fin) r_blk_count <= CNT_W'(r_blk_count + 1'b1);
    end
  end

  assign blk_done  = r_blk_done;
  assign blk_count = r_blk_count;

endmodule

// File: tb/tb_dct_block_ctrl.sv
// Self-checking bench for dct_block_ctrl with a behavioural double_counter.
// Timeout scenario runs only when DCT_CTRL_TIMEOUT_EN is defined.
module tb_dct_block_ctrl;

  localparam int CNT_W = 2;
  localparam int TO    = 16;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, coef_ready = 1'b1;
  logic start_ready, dc_restart, dc_go, dc_done, coef_valid, blk_done, busy, err;
  logic [2:0] dc_u, dc_v, coef_u, coef_v;
  logic [CNT_W-1:0] blk_count;

  int checks = 0, failures = 0;
  logic [5:0] q[$];
  int hs, ndone, nrst, t_rst1, t_rst2, t_valid, t_last, t_done, nstall_seen;
  int cnt_seen[8];

  always #5 clk = ~clk;

  dct_block_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .dc_restart(dc_restart), .dc_go(dc_go), .dc_u(dc_u), .dc_v(dc_v),
    .dc_done(dc_done), .coef_valid(coef_valid), .coef_u(coef_u),
    .coef_v(coef_v), .coef_ready(coef_ready), .blk_done(blk_done),
    .busy(busy), .blk_count(blk_count), .err(err)
  );

  // double_counter model: v fastest, done after the (7,7) step
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dc_u <= 3'd0; dc_v <= 3'd0; dc_done <= 1'b0;
    end else if (dc_restart) begin
      dc_u <= 3'd0; dc_v <= 3'd0; dc_done <= 1'b0;
    end else if (dc_go && !dc_done) begin
      if (dc_v == 3'd7) begin
        dc_v <= 3'd0;
        if (dc_u == 3'd7) begin dc_u <= 3'd0; dc_done <= 1'b1; end
        else dc_u <= dc_u + 3'd1;
      end else dc_v <= dc_v + 3'd1;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    q.delete();
  endtask

  // Holds start until nblk restarts seen; scoreboard pushes 64 indices per restart
  task automatic run_blocks(input int nblk, input int su, input int sv,
                            input int nstall, input int abort_hs);
    int n = 0;
    int left = nstall;
    bit rdy;
    logic [5:0] e;
    hs = 0; ndone = 0; nrst = 0; t_rst1 = -1; t_rst2 = -1; t_valid = -1;
    t_last = -1; t_done = -1; nstall_seen = 0;
    start = 1'b1;
    while (1) begin
      @(negedge clk); n++;
      if (dc_restart) begin
        nrst++;
        if (nrst == 1) t_rst1 = n;
        if (nrst == 2) t_rst2 = n;
        for (int u = 0; u < 8; u++)
          for (int v = 0; v < 8; v++) q.push_back({u[2:0], v[2:0]});
        if (nrst >= nblk) start = 1'b0;
      end
      if (coef_valid && t_valid < 0) t_valid = n;
      rdy = !(coef_valid && left > 0 && coef_u == su[2:0] && coef_v == sv[2:0]);
      if (!rdy) begin left--; nstall_seen++; end
      coef_ready = rdy;
      #1;
      checks++;
      if (dc_go !== (coef_valid && rdy)) begin
        failures++;
        $display("FAIL dc_go cyc=%0d got=%b exp=%b", n, dc_go, coef_valid && rdy);
      end
      if (coef_valid && rdy) begin
        hs++; t_last = n;
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL coef_idx unexpected handshake cyc=%0d got=(%0d,%0d)", n, coef_u, coef_v);
        end else begin
          e = q.pop_front();
          if ({coef_u, coef_v} !== e) begin
            failures++;
            $display("FAIL coef_idx cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", n, coef_u, coef_v, e[5:3], e[2:0]);
          end
        end
        if (hs == abort_hs) begin start = 1'b0; return; end
      end
      if (blk_done) begin
        if (ndone < 8) cnt_seen[ndone] = blk_count;
        ndone++; t_done = n;
        checks++;
        if (start_ready !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL idle_at_done got start_ready=%b busy=%b exp=1,0", start_ready, busy);
        end
        if (ndone == nblk) break;
      end
      if (n >= 100 * nblk + 20) begin
        checks++; failures++;
        $display("FAIL timeout cyc=%0d done=%0d exp=%0d", n, ndone, nblk);
        break;
      end
    end
    start = 1'b0;
    coef_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || blk_count !== '0 || err !== 1'b0 ||
        coef_valid !== 1'b0 || dc_restart !== 1'b0 || blk_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got sr=%b busy=%b cnt=%0d err=%b cv=%b rs=%b bd=%b exp=1,0,0,0,0,0,0",
               start_ready, busy, blk_count, err, coef_valid, dc_restart, blk_done);
    end
    do_reset();
  endtask

  task automatic test_nominal();
    run_blocks(1, -1, -1, 0, 0);
    checks++;
    if (t_rst1 != 1 || t_valid != 2 || t_last != 65 || t_done != 67) begin
      failures++;
      $display("FAIL nominal_timing got rst=%0d valid=%0d last=%0d done=%0d exp=1,2,65,67",
               t_rst1, t_valid, t_last, t_done);
    end
    checks++;
    if (hs != 64 || nrst != 1 || q.size() != 0) begin
      failures++;
      $display("FAIL nominal_hs got hs=%0d restarts=%0d left=%0d exp=64,1,0", hs, nrst, q.size());
    end
    checks++;
    if (blk_count !== 2'd1 || err !== 1'b0) begin
      failures++;
      $display("FAIL nominal_count got cnt=%0d err=%b exp=1,0", blk_count, err);
    end
  endtask

  task automatic test_backpressure();
    run_blocks(1, 2, 5, 3, 0);
    checks++;
    if (hs != 64 || nstall_seen != 3 || t_done != 70) begin
      failures++;
      $display("FAIL backpressure got hs=%0d stalls=%0d done=%0d exp=64,3,70", hs, nstall_seen, t_done);
    end
    checks++;
    if (blk_count !== 2'd2) begin
      failures++;
      $display("FAIL backpressure_count got=%0d exp=2", blk_count);
    end
  endtask

  task automatic test_reset_mid_issue();
    run_blocks(1, -1, -1, 0, 10);
    rst_n = 1'b0;
    #1;
    checks++;
    if (start_ready !== 1'b1 || busy !== 1'b0 || coef_valid !== 1'b0 || blk_count !== '0) begin
      failures++;
      $display("FAIL reset_mid got sr=%b busy=%b cv=%b cnt=%0d exp=1,0,0,0",
               start_ready, busy, coef_valid, blk_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    run_blocks(1, -1, -1, 0, 0);
    checks++;
    if (hs != 64 || t_valid != 2 || blk_count !== 2'd1) begin
      failures++;
      $display("FAIL reset_restart got hs=%0d valid=%0d cnt=%0d exp=64,2,1", hs, t_valid, blk_count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run_blocks(2, -1, -1, 0, 0);
    checks++;
    if (ndone != 2 || nrst != 2 || t_rst2 != 68 || hs != 128 || blk_count !== 2'd2) begin
      failures++;
      $display("FAIL back_to_back got done=%0d rst=%0d rst2=%0d hs=%0d cnt=%0d exp=2,2,68,128,2",
               ndone, nrst, t_rst2, hs, blk_count);
    end
  endtask

  task automatic test_wrap();
    int exp_w[5] = '{1, 2, 3, 0, 1};
    do_reset();
    run_blocks(5, -1, -1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cnt_seen[i] != exp_w[i] || ndone != 5) begin
        failures++;
        $display("FAIL wrap blk=%0d got=%0d exp=%0d done=%0d", i, cnt_seen[i], exp_w[i], ndone);
      end
    end
  endtask

`ifdef DCT_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    bit saw_rs = 1'b0;
    do_reset();
    coef_ready = 1'b0;
    start = 1'b1;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (n == 17) begin
        checks++;
        if (err !== 1'b0 || coef_valid !== 1'b1) begin
          failures++;
          $display("FAIL timeout_early got err=%b cv=%b exp=0,1", err, coef_valid);
        end
      end
    end
    checks++;
    if (err !== 1'b1 || coef_valid !== 1'b0 || start_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_err got err=%b cv=%b sr=%b busy=%b exp=1,0,0,1", err, coef_valid, start_ready, busy);
    end
    start = 1'b1;
    coef_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (dc_restart || blk_done) saw_rs = 1'b1;
    end
    start = 1'b0;
    checks++;
    if (saw_rs || err !== 1'b1 || blk_count !== '0) begin
      failures++;
      $display("FAIL timeout_sticky got restart_or_done=%b err=%b cnt=%0d exp=0,1,0", saw_rs, err, blk_count);
    end
    do_reset();
    checks++;
    if (err !== 1'b0 || start_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_clear got err=%b sr=%b exp=0,1", err, start_ready);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_reset_mid_issue();
    test_back_to_back();
    test_wrap();
`ifdef DCT_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dct_block_ctrl.md
# dct_block_ctrl

Sequencing controller for the 8x8 transform stage. Accepts one block-start request at a time, restarts and steps the external `double_counter` (u,v index generator), and issues one coefficient request per (u,v) to the transform datapath under a valid/ready handshake. Signals block completion and keeps a running block count.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: watchdog limit in cycles. Used only with `DCT_CTRL_TIMEOUT_EN`.
- `CNT_W`, 16: width of `blk_count`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: block-start request, level-sensitive.
- `start_ready` out 1: controller idle. Start is accepted when `start && start_ready`.
- `dc_restart` out 1: to `double_counter.restart`.
- `dc_go` out 1: to `double_counter.go`.
- `dc_u`, `dc_v` in 3: from `double_counter.u/.v`.
- `dc_done` in 1: from `double_counter.done`.
- `coef_valid` out 1: coefficient request valid.
- `coef_u`, `coef_v` out 3: coefficient index. Combinational copy of `dc_u`/`dc_v`.
- `coef_ready` in 1: datapath accepts the request.
- `blk_done` out 1: one-cycle pulse when a block completes.
- `busy` out 1: high whenever the state is not IDLE.
- `blk_count` out `CNT_W`: number of completed blocks.
- `err` out 1: watchdog fault, sticky. Only present with the macro; otherwise tied to 0.

## Operation
- States: IDLE, RESTART, ISSUE, WAIT_DONE. ERROR exists only with the macro.
- IDLE:
  - `start_ready`=1.
  - On `start && start_ready`, go to RESTART.
  - `start` while not IDLE is ignored; the request is not queued.
- RESTART: `dc_restart`=1 for exactly one cycle, then go to ISSUE.
- ISSUE:
  - `coef_valid`=1, `coef_u/v`=`dc_u/v`.
  - `dc_go` = `coef_valid && coef_ready`, combinational. The counter advances one step per handshake only.
  - `coef_valid` stays high and `coef_u/v` stay stable while `coef_ready`=0.
  - A handshake with `coef_u==7 && coef_v==7` is the last one; go to WAIT_DONE.
- WAIT_DONE:
  - `coef_valid`=0, `dc_go`=0.
  - On the first cycle with `dc_done`=1: pulse `blk_done`, increment `blk_count`, go to IDLE.
- `blk_count` wraps from all-ones to 0.
- `coef_ready` outside ISSUE is ignored. `dc_done` outside WAIT_DONE is ignored.
- Reset, asynchronous, any state:
  - State goes to IDLE; `blk_count`=0; `err`=0.
  - All registered outputs go to 0.
  - `start_ready`=1 during reset. `coef_valid`, `dc_go`, `dc_restart`, `blk_done` and `busy` are 0.
  - A block interrupted by reset is discarded. The next start re-restarts the counter.

## Timing
- Start accepted at edge T:
  - T+1: RESTART, `dc_restart`=1.
  - T+2: ISSUE, first `coef_valid`, index (0,0).
- With `coef_ready` held high:
  - 64 consecutive handshakes over T+2..T+65, v incrementing fastest.
  - WAIT_DONE from T+66.
- `dc_done` seen high at cycle D: `blk_done`=1 at D+1, `blk_count` updated at D+1, IDLE and `start_ready`=1 at D+1.
- Minimum start-to-start spacing: 67 cycles, when `dc_done` is already asserted on entry to WAIT_DONE.
- Each `coef_ready` stall cycle adds exactly one cycle.

## Configuration
- Macro `DCT_CTRL_TIMEOUT_EN`.
- Defined:
  - A watchdog counts consecutive cycles in ISSUE with `coef_ready`=0, or in WAIT_DONE with `dc_done`=0.
  - The count resets on any handshake or state change.
  - When the count reaches `TIMEOUT_CYCLES`: set `err`, go to ERROR.
  - ERROR drives `coef_valid`=0, `start_ready`=0 and `busy`=1 until `rst_n`.
  - `blk_done` does not pulse and `blk_count` is unchanged.
- Undefined: no watchdog and no ERROR state; `err` is constant 0. The controller waits indefinitely.

## Structure
- Package `dct_ctrl_pkg` holds:
  - the state enum;
  - `BLK_DIM`=8, `IDX_W`=3, `LAST_IDX`=7;
  - the default `TIMEOUT_CYCLES`.
- Sub-module `dct_ctrl_watchdog` holds the stall counter and its limit compare. It is instantiated only under the macro.
- `double_counter` is instantiated next to this block by the parent, not inside it.

## Test plan
- Reset then idle: `rst_n` low at any point -> `start_ready`=1, `busy`=0, `blk_count`=0. Reset mid-ISSUE (after 10 handshakes) -> IDLE next cycle; the next block starts again at (0,0).
- Nominal block: `start` at T, `coef_ready`=1, `double_counter` model -> `dc_restart` at T+1; indices (0,0),(0,1)…(7,7) over T+2..T+65; `blk_done` one cycle after `dc_done`; `blk_count`=1.
- Backpressure: `coef_ready` low for 3 cycles at index (2,5) -> `coef_u/v` hold at (2,5), `dc_go`=0 for those cycles, exactly 64 handshakes total.
- Start while busy: `start` held high through a block -> the second block starts only after `blk_done`. Two blocks completed -> `blk_count`=2.
- Count wrap: `CNT_W`=2, 5 blocks -> `blk_count` reads 1,2,3,0,1.
- Timeout (macro, `TIMEOUT_CYCLES`=16): `coef_ready` held 0 in ISSUE -> `err`=1 after 16 stalled cycles, `coef_valid`=0, `start` ignored until reset.
